// File: rtl/exec_dispatch.sv
// exec_dispatch: execute stage that accepts one decoded instruction, issues it
// to one of NUM_UNITS external functional units over req/done, resolves
// jal/jalr/conditional branches, and holds a registered result for writeback.
// Optional watchdog: define EXEC_TIMEOUT_EN to bound the wait for u_done by
// TIMEOUT cycles (expiry completes the op with out_err=1).
module exec_dispatch #(
    parameter int XLEN      = 32,
    parameter int NUM_UNITS = 2,
    parameter int UW        = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [UW-1:0]             in_unit,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [XLEN-1:0]           in_imm,
    input  logic [XLEN-1:0]           in_rs1,
    input  logic [XLEN-1:0]           in_rs2,
    input  logic [4:0]                in_rd,
    input  logic                      in_jal,
    input  logic                      in_jalr,
    input  logic                      in_cond,
    output logic [NUM_UNITS-1:0]      u_req,
    output logic [XLEN-1:0]           u_rs1,
    output logic [XLEN-1:0]           u_rs2,
    output logic [XLEN-1:0]           u_imm,
    output logic [XLEN-1:0]           u_pc,
    input  logic [NUM_UNITS-1:0]      u_done,
    input  logic [NUM_UNITS*XLEN-1:0] u_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_result,
    output logic [4:0]                out_rd,
    output logic                      out_jump,
    output logic [XLEN-1:0]           out_jump_dest,
    output logic                      out_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    if (NUM_UNITS < 1 || NUM_UNITS > 8 || (1 << UW) < NUM_UNITS || TIMEOUT < 1) begin : g_bad_cfg
        $error("exec_dispatch: invalid parameter set");
    end

    logic [1:0]      state;
    logic [UW-1:0]   unit_q;
    logic [4:0]      rd_q;
    logic            cond_q;
    logic            sel_done;
    logic [XLEN-1:0] sel_result;
    logic            accept;
    logic            busy;
    logic            is_jump;
    logic            bad_unit;
    logic            enter_issue;
    logic            tmo_hit;
    logic            taken;
    logic [XLEN-1:0] jal_dest;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] br_dest;

    // Select the done flag and result of the unit the current op was issued to
    always_comb begin
        sel_done   = 1'b0;
        sel_result = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (unit_q == UW'(i)) begin
                sel_done   = u_done[i];
                sel_result = u_result[i*XLEN +: XLEN];
            end
        end
    end

    assign in_ready    = !flush && (state == S_IDLE || (state == S_DONE && out_ready));
    assign accept      = in_valid && in_ready;
    assign busy        = (state == S_ISSUE) || (state == S_WAIT);
    assign is_jump     = in_jal || in_jalr;
    assign bad_unit    = {1'b0, in_unit} >= (UW+1)'(NUM_UNITS);
    assign enter_issue = accept && !is_jump && !bad_unit;
    assign out_valid   = (state == S_DONE);

    assign jal_dest = in_pc + in_imm;
    assign jalr_sum = in_rs1 + in_imm;
    assign br_dest  = u_pc + u_imm;
    assign taken    = cond_q && (sel_result == XLEN'(1));

    // Issue pulse is a decode of the ISSUE state, so it lasts exactly one cycle
    always_comb begin
        u_req = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (state == S_ISSUE && unit_q == UW'(i)) u_req[i] = 1'b1;
        end
    end

`ifdef EXEC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt;

    // Watchdog: cleared when an op is issued, counts every ISSUE/WAIT cycle
    always_ff @(posedge clk) begin
        if (!rstn)            tmo_cnt <= '0;
        else if (enter_issue) tmo_cnt <= '0;
        else if (busy)        tmo_cnt <= tmo_cnt + CW'(1);
    end

    // Fires in the TIMEOUT-th ISSUE/WAIT cycle; a u_done in that cycle still wins
    assign tmo_hit = busy && (tmo_cnt == CW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Control FSM plus operand latch and result capture on entry to DONE
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= S_IDLE;
            unit_q        <= '0;
            rd_q          <= '0;
            cond_q        <= 1'b0;
            u_rs1         <= '0;
            u_rs2         <= '0;
            u_imm         <= '0;
            u_pc          <= '0;
            out_result    <= '0;
            out_rd        <= '0;
            out_jump      <= 1'b0;
            out_jump_dest <= '0;
            out_err       <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        unit_q <= in_unit;
                        rd_q   <= in_rd;
                        cond_q <= in_cond;
                        u_rs1  <= in_rs1;
                        u_rs2  <= in_rs2;
                        u_imm  <= in_imm;
                        u_pc   <= in_pc;
                        if (is_jump) begin
                            state         <= S_DONE;
                            out_result    <= in_pc + XLEN'(4);
                            out_rd        <= in_rd;
                            out_jump      <= 1'b1;
                            out_jump_dest <= in_jal ? jal_dest : {jalr_sum[XLEN-1:1], 1'b0};
                            out_err       <= 1'b0;
                        end else if (bad_unit) begin
                            state         <= S_DONE;
                            out_result    <= '0;
                            out_rd        <= in_rd;
                            out_jump      <= 1'b0;
                            out_jump_dest <= '0;
                            out_err       <= 1'b1;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end else if (state == S_DONE && out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    if (sel_done) begin
                        state         <= S_DONE;
                        out_result    <= sel_result;
                        out_rd        <= rd_q;
                        out_jump      <= taken;
                        out_jump_dest <= taken ? br_dest : '0;
                        out_err       <= 1'b0;
                    end else if (tmo_hit) begin
                        state         <= S_DONE;
                        out_result    <= '0;
                        out_rd        <= rd_q;
                        out_jump      <= 1'b0;
                        out_jump_dest <= '0;
                        out_err       <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_dispatch.sv
// Scoreboard bench for exec_dispatch: stimulus pushes expected results into a
// queue, an independent monitor pops and compares on each output handshake.
module tb_exec_dispatch;

    localparam int XLEN = 32;
    localparam int NU   = 2;
    localparam int UW   = 3;
`ifdef EXEC_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic            clk = 1'b0;
    logic            rstn, flush, in_valid, in_ready;
    logic [UW-1:0]   in_unit;
    logic [XLEN-1:0] in_pc, in_imm, in_rs1, in_rs2;
    logic [4:0]      in_rd;
    logic            in_jal, in_jalr, in_cond;
    logic [NU-1:0]   u_req;
    logic [XLEN-1:0] u_rs1, u_rs2, u_imm, u_pc;
    logic [NU-1:0]   u_done;
    logic [NU*XLEN-1:0] u_result;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_result, out_jump_dest;
    logic [4:0]      out_rd;
    logic            out_jump, out_err;

    typedef struct {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            jump;
        logic [XLEN-1:0] dest;
        logic            err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    exec_dispatch #(.XLEN(XLEN), .NUM_UNITS(NU), .UW(UW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_unit(in_unit),
        .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rd(in_rd), .in_jal(in_jal), .in_jalr(in_jalr), .in_cond(in_cond),
        .u_req(u_req), .u_rs1(u_rs1), .u_rs2(u_rs2), .u_imm(u_imm), .u_pc(u_pc),
        .u_done(u_done), .u_result(u_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_jump(out_jump), .out_jump_dest(out_jump_dest),
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [XLEN-1:0] r, input logic [4:0] rd, input logic j,
                        input logic [XLEN-1:0] d, input logic e);
        exp_t x;
        x.result = r; x.rd = rd; x.jump = j; x.dest = d; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic present(input logic [UW-1:0] unit, input logic [XLEN-1:0] pc,
                           input logic [XLEN-1:0] imm, input logic [XLEN-1:0] rs1,
                           input logic [4:0] rd, input logic jal, input logic jalr,
                           input logic cond);
        in_valid = 1'b1; in_unit = unit; in_pc = pc; in_imm = imm; in_rs1 = rs1;
        in_rs2 = rs1 ^ 32'h0000_00FF; in_rd = rd; in_jal = jal; in_jalr = jalr; in_cond = cond;
    endtask

    task automatic unit_done(input int u, input logic [XLEN-1:0] r);
        u_done = '0;
        u_done[u] = 1'b1;
        u_result[u*XLEN +: XLEN] = r;
    endtask

    // Monitor: compare against the scoreboard on every output handshake,
    // and check the outputs stay frozen while the handshake is stalled
    logic            prev_valid = 1'b0, prev_ready = 1'b0;
    logic [XLEN-1:0] prev_result, prev_dest;
    logic [4:0]      prev_rd;
    logic            prev_jump, prev_err;
    always @(negedge clk) begin
        if (rstn && out_valid && prev_valid && !prev_ready) begin
            check("hold_result", out_result, prev_result);
            check("hold_dest", out_jump_dest, prev_dest);
            check("hold_rd", out_rd, prev_rd);
            check("hold_jump_err", {out_jump, out_err}, {prev_jump, prev_err});
        end
        if (rstn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("out_result", out_result, x.result);
                check("out_rd", out_rd, x.rd);
                check("out_jump", out_jump, x.jump);
                check("out_jump_dest", out_jump_dest, x.dest);
                check("out_err", out_err, x.err);
            end
        end
        prev_valid = out_valid && rstn; prev_ready = out_ready;
        prev_result = out_result; prev_dest = out_jump_dest; prev_rd = out_rd;
        prev_jump = out_jump; prev_err = out_err;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_unit = '0; in_pc = '0; in_imm = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_jal = 1'b0; in_jalr = 1'b0; in_cond = 1'b0;
        u_done = '0; u_result = '0; out_ready = 1'b1;
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_u_req", u_req, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_dest", out_jump_dest, 0);
        check("rst_out_err_jump", {out_err, out_jump}, 0);
        check("rst_u_rs1", u_rs1, 0);
        check("rst_in_ready", in_ready, 1);
        rstn = 1'b1;
        tick();

        // ALU add: unit 0 answers in the issue cycle
        present(0, 32'h40, 32'h0, 32'h3, 5'd5, 0, 0, 0);
        push(32'h7, 5'd5, 0, 32'h0, 0);
        tick();
        in_valid = 1'b0;
        check("alu_u_req", u_req, 2'b01);
        check("alu_u_rs1", u_rs1, 32'h3);
        check("alu_early_valid", out_valid, 0);
        unit_done(0, 32'h7);
        tick();
        u_done = '0;
        check("alu_valid_lat2", out_valid, 1);
        check("alu_req_pulse", u_req, 0);
        tick();
        check("alu_drained", out_valid, 0);

        // jalr: 1-cycle latency, bit 0 of target cleared
        present(0, 32'h100, 32'h4, 32'h2003, 5'd1, 0, 1, 0);
        push(32'h104, 5'd1, 1, 32'h2006, 0);
        tick();
        in_valid = 1'b0;
        check("jalr_valid_lat1", out_valid, 1);
        check("jalr_no_req", u_req, 0);
        tick();

        // jal wins over jalr and cond when all are set
        present(1, 32'h200, 32'h20, 32'hFFFF, 5'd2, 1, 1, 1);
        push(32'h204, 5'd2, 1, 32'h220, 0);
        tick();
        in_valid = 1'b0;
        check("jal_no_req", u_req, 0);
        tick();

        // Taken branch whose target wraps past 2**32
        present(0, 32'hFFFF_FFF8, 32'h10, 32'h0, 5'd0, 0, 0, 1);
        push(32'h1, 5'd0, 1, 32'h0000_0008, 0);
        tick();
        in_valid = 1'b0;
        unit_done(0, 32'h1);
        tick();
        u_done = '0;
        tick();

        // Not-taken branch on unit 1, one WAIT cycle
        present(1, 32'h500, 32'h40, 32'h0, 5'd4, 0, 0, 1);
        push(32'h0, 5'd4, 0, 32'h0, 0);
        tick();
        in_valid = 1'b0;
        tick();
        unit_done(1, 32'h0);
        tick();
        u_done = '0;
        tick();

        // Multi-cycle unit 1 with spurious u_done[0], stalled output, back-to-back jal
        out_ready = 1'b0;
        present(1, 32'h600, 32'h0, 32'hA, 5'd7, 0, 0, 0);
        push(32'hDEAD_BEEF, 5'd7, 0, 32'h0, 0);
        tick();
        in_valid = 1'b0;
        check("mc_u_req", u_req, 2'b10);
        unit_done(0, 32'h55);
        tick();
        u_done = '0;
        check("mc_wait_no_req", u_req, 0);
        check("mc_ignore_spurious", out_valid, 0);
        tick();
        unit_done(0, 32'h66);
        tick();
        u_done = '0;
        tick();
        unit_done(1, 32'hDEAD_BEEF);
        check("mc_not_yet", out_valid, 0);
        tick();
        u_done = '0;
        present(0, 32'h1000, 32'h8, 32'h0, 5'd3, 1, 0, 0);
        push(32'h1004, 5'd3, 1, 32'h1008, 0);
        for (int i = 0; i < 3; i++) begin
            check("mc_hold_valid", out_valid, 1);
            check("mc_hold_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("mc_drain_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("b2b_valid", out_valid, 1);
        tick();

        // Invalid unit index: no request, error result
        present(5, 32'h700, 32'h0, 32'h1, 5'd9, 0, 0, 0);
        push(32'h0, 5'd9, 0, 32'h0, 1);
        tick();
        in_valid = 1'b0;
        check("bad_no_req", u_req, 0);
        check("bad_valid", out_valid, 1);
        tick();

        // Flush during WAIT, then a late u_done and a blocked in_valid
        present(1, 32'h800, 32'h0, 32'h2, 5'd6, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        present(1, 32'h900, 32'h0, 32'h3, 5'd8, 0, 0, 0);
        #1;
        check("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_req", u_req, 0);
        check("flush_valid", out_valid, 0);
        unit_done(1, 32'h1234);
        tick();
        u_done = '0;
        check("late_done_valid", out_valid, 0);
        check("late_done_idle", in_ready, 1);
        tick();
        check("flush_no_issue", u_req, 0);

`ifdef EXEC_TIMEOUT_EN
        // Unit never answers: error after TMO cycles in ISSUE/WAIT
        present(0, 32'hA00, 32'h0, 32'h0, 5'd10, 0, 0, 0);
        push(32'h0, 5'd10, 0, 32'h0, 1);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < TMO; i++) tick();
        check("tmo_not_yet", out_valid, 0);
        tick();
        check("tmo_valid", out_valid, 1);
        tick();
        // u_done in the final watchdog cycle completes normally
        present(0, 32'hB00, 32'h0, 32'h0, 5'd11, 0, 0, 0);
        push(32'h42, 5'd11, 0, 32'h0, 0);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < TMO; i++) tick();
        unit_done(0, 32'h42);
        tick();
        u_done = '0;
        check("tmo_race_valid", out_valid, 1);
        tick();
`endif

        tick(); tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exec_dispatch.md
Name: exec_dispatch

Overview:
Parametrised next-generation execute stage. Accepts one decoded instruction per valid/ready handshake and dispatches it to one of NUM_UNITS external functional units (ALU, FPU, MUL/DIV, ...) over a req/done handshake. It resolves jumps and branches internally and presents a registered result to writeback behind a valid/ready handshake, with flush support. Sits between decode and writeback.

Parameters:
XLEN, 32, datapath width for pc, imm, operands, result and jump destination.
NUM_UNITS, 2, number of functional-unit channels (1..8).
UW, 3, width of the unit-select field; must satisfy 2**UW >= NUM_UNITS.
TIMEOUT, 64, watchdog limit in cycles; used only with EXEC_TIMEOUT_EN.

Ports:
clk  in  1  clock.
rstn  in  1  reset. Synchronous, active-low.
flush  in  1  synchronous pipeline flush.
in_valid  in  1  upstream instruction valid.
in_ready  out  1  stage can accept.
in_unit  in  UW  target unit index.
in_pc  in  XLEN  instruction pc.
in_imm  in  XLEN  sign-extended immediate.
in_rs1  in  XLEN  operand 1.
in_rs2  in  XLEN  operand 2.
in_rd  in  5  destination register.
in_jal  in  1  jal.
in_jalr  in  1  jalr.
in_cond  in  1  conditional branch.
u_req  out  NUM_UNITS  one-hot single-cycle issue pulse.
u_rs1, u_rs2, u_imm, u_pc  out  XLEN each  latched operands, broadcast to all units.
u_done  in  NUM_UNITS  per-unit completion.
u_result  in  NUM_UNITS*XLEN  per-unit result; unit i occupies bits [i*XLEN +: XLEN].
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts.
out_result  out  XLEN  result.
out_rd  out  5  destination register.
out_jump  out  1  jump taken.
out_jump_dest  out  XLEN  jump target.
out_err  out  1  error (invalid unit or timeout).

Behaviour:
- Reset (rstn=0 at clk edge): state IDLE; u_req=0; out_valid=0; out_result=0; out_rd=0; out_jump=0; out_jump_dest=0; out_err=0; u_* operand registers=0. Reset mid-operation abandons the instruction; a late u_done is ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- in_ready is high when state=IDLE, or when state=DONE and out_ready=1, and only if flush=0.
- Accept (in_valid & in_ready): latch all inputs.
  - jal or jalr: go to DONE; no unit request.
  - Otherwise, if in_unit >= NUM_UNITS: go to DONE with result 0 and out_err=1.
  - Otherwise: go to ISSUE.
- ISSUE: u_req[unit]=1 for exactly one cycle. If u_done[unit] is seen this cycle, go to DONE; else go to WAIT.
- WAIT: hold until u_done[unit], then go to DONE. u_done from non-selected units is ignored.
- Results are captured on the edge that enters DONE, so out_valid rises the next cycle.
  - Minimum unit latency: 2 cycles from accept to out_valid.
  - jal/jalr latency: 1 cycle.
- DONE: out_valid=1 and all out_* held stable until out_ready. On out_ready: go to IDLE, or to a new ISSUE/DONE if a new instruction is accepted the same cycle (back-to-back).
- Result rules (all sums modulo 2**XLEN, wrap ignored):
  - jal: result = pc+4; jump=1; dest = pc+imm.
  - jalr: result = pc+4; jump=1; dest = (rs1+imm) with bit 0 cleared.
  - cond: result = unit result; jump = (unit result == 1); dest = pc+imm if taken, else 0.
  - Other: result = unit result; jump=0; dest=0.
  - jal takes priority over jalr, and jalr over cond, if several flags are set.
- flush: on the next edge, state returns to IDLE, out_valid=0, u_req=0, and the in-flight op is dropped. An in_valid presented during flush is not accepted. Flush overrides a simultaneous out_ready handshake.

Optional Feature:
EXEC_TIMEOUT_EN:
- Defined: a counter clears on entry to ISSUE and increments every cycle in ISSUE/WAIT. On reaching TIMEOUT without u_done, go to DONE with result 0, jump=0, out_err=1. A u_done arriving in the same cycle the counter reaches TIMEOUT wins (normal completion, out_err=0).
- Undefined: no counter; WAIT is unbounded. out_err is set only for an invalid unit index.

Test Plan:
- ALU add: unit 0, done the same cycle as req, result 0x0000_0007 -> out_valid 2 cycles after accept; out_result=7, out_jump=0, out_jump_dest=0.
- jalr: pc=0x100, rs1=0x2003, imm=0x4 -> 1-cycle latency; out_result=0x104, out_jump=1, out_jump_dest=0x2006.
- Branch taken: pc=0xFFFF_FFF8, imm=0x10, unit 0 returns 1 -> out_jump=1, out_jump_dest=0x0000_0008 (wrap).
- Multi-cycle unit 1: done after 5 cycles, out_ready held low 3 cycles, spurious u_done[0] injected -> single out_valid, outputs stable, u_done[0] ignored; back-to-back next op accepted on the drain cycle.
- Invalid unit 5 with NUM_UNITS=2 -> no u_req; out_err=1, out_result=0. Flush during WAIT, then late u_done -> out_valid stays 0 and state is IDLE.
- EXEC_TIMEOUT_EN, TIMEOUT=8, unit never done -> out_valid with out_err=1 after 8 cycles in ISSUE/WAIT; with u_done on cycle 8 -> out_err=0.
